// File: rtl/seg7_time_scan.sv
// seg7_time_scan: scans the six HH:MM:SS BCD digits onto a six-digit,
// common-anode, multiplexed 7-segment display (all outputs active-low).
// A full frame of digits is snapshotted at the start of every frame so the
// display never tears. Each digit slot opens with a short all-anodes-off
// interval to hide segment changes. The field under adjustment blinks.
// Optional feature macro: SEG7_LZ_BLANK_EN blanks a leading zero in the
// hours-tens digit (slot 5).
module seg7_time_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h_cntH,
    input  logic [3:0] h_cntL,
    input  logic [3:0] m_cntH,
    input  logic [3:0] m_cntL,
    input  logic [3:0] s_cntH,
    input  logic [3:0] s_cntL,
    input  logic       blink_hr,
    input  logic       blink_min,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] an_n
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
    localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic [PW-1:0] p;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          ph;

    // Frame snapshot: digits packed {hH, hL, mH, mL, sH, sL}, plus blink
    // requests. snap_vld keeps the all-zero reset snapshot off the display.
    logic [23:0]   snap_dig;
    logic          snap_bh;
    logic          snap_bm;
    logic          snap_vld;

    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [5:0]    an_nxt;

    // Active-low 7-segment patterns; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Slot prescaler, digit index, and frame counter driving the blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            p         <= '0;
            idx       <= 3'd0;
            frame_cnt <= '0;
            ph        <= 1'b0;
        end else if (p == P_LAST) begin
            p <= '0;
            if (idx == 3'd5) begin
                idx <= 3'd0;
                if (frame_cnt == F_LAST) begin
                    frame_cnt <= '0;
                    ph        <= ~ph;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end else begin
                idx <= idx + 3'd1;
            end
        end else begin
            p <= p + PW'(1);
        end
    end

    // Capture the whole display frame at the first cycle of slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_dig <= 24'h0;
            snap_bh  <= 1'b0;
            snap_bm  <= 1'b0;
            snap_vld <= 1'b0;
        end else if (p == '0 && idx == 3'd0) begin
            snap_dig <= {h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL};
            snap_bh  <= blink_hr;
            snap_bm  <= blink_min;
            snap_vld <= 1'b1;
        end
    end

    // Select the current slot's digit and compute the next output values.
    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = snap_dig[3:0];
            3'd1:    digit = snap_dig[7:4];
            3'd2:    digit = snap_dig[11:8];
            3'd3:    digit = snap_dig[15:12];
            3'd4:    digit = snap_dig[19:16];
            3'd5:    digit = snap_dig[23:20];
            default: digit = 4'd0;
        endcase

        blank = 1'b0;
        if (ph && snap_bm && (idx == 3'd2 || idx == 3'd3))
            blank = 1'b1;
        if (ph && snap_bh && (idx == 3'd4 || idx == 3'd5))
            blank = 1'b1;
        if (LZ_EN && idx == 3'd5 && digit == 4'd0)
            blank = 1'b1;

        seg_nxt = seg_decode(digit);
        dp_nxt  = !(idx == 3'd2 || idx == 3'd4);
        if (blank || !snap_vld) begin
            seg_nxt = 7'h7F;
            dp_nxt  = 1'b1;
        end

        an_nxt = (p < P_BLANK) ? 6'h3F : ~(6'b000001 << idx);
    end

    // Register every pin so the board sees glitch-free, one-cycle-late outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            an_n  <= 6'h3F;
        end else begin
            seg_n <= seg_nxt;
            dp_n  <= dp_nxt;
            an_n  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_time_scan.sv
// tb_seg7_time_scan: directed frames of HH:MM:SS digits; expected slot
// contents are pushed when each frame is issued, and a monitor pops one entry
// every time a digit anode switches on.
`timescale 1ns/1ps
module tb_seg7_time_scan;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] h_cntH = 4'd0, h_cntL = 4'd0, m_cntH = 4'd0;
    logic [3:0] m_cntL = 4'd0, s_cntH = 4'd0, s_cntL = 4'd0;
    logic       blink_hr = 1'b0, blink_min = 1'b0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [5:0] an_n;

    int checks = 0;
    int errors = 0;
    int fr_num = 0;

    // Expected slot entries: {seg_n, dp_n, an_n}
    logic [13:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    seg7_time_scan #(
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .h_cntH(h_cntH),
        .h_cntL(h_cntL),
        .m_cntH(m_cntH),
        .m_cntL(m_cntL),
        .s_cntH(s_cntH),
        .s_cntL(s_cntL),
        .blink_hr(blink_hr),
        .blink_min(blink_min),
        .seg_n(seg_n),
        .dp_n(dp_n),
        .an_n(an_n)
    );

    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;
            4'd3: s = 7'h30;  4'd4: s = 7'h19;  4'd5: s = 7'h12;
            4'd6: s = 7'h02;  4'd7: s = 7'h78;  4'd8: s = 7'h00;
            4'd9: s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present a frame's inputs and push the six slot expectations.
    task automatic start_frame(input logic [23:0] dig, input logic bh, input logic bm);
        logic       ph;
        logic [3:0] d;
        logic [6:0] s;
        logic       dp;
        logic       blank;
        {h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL} = dig;
        blink_hr  = bh;
        blink_min = bm;
        ph = (((fr_num / BLINK_FRAMES) % 2) == 1);
        for (int i = 0; i < 6; i++) begin
            d     = dig[i*4 +: 4];
            s     = pat(d);
            dp    = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            blank = ph && ((bm && (i == 2 || i == 3)) || (bh && (i == 4 || i == 5)));
            if (LZ_EN && i == 5 && d == 4'd0) blank = 1'b1;
            if (blank) begin
                s  = 7'h7F;
                dp = 1'b1;
            end
            exp_q.push_back({s, dp, 6'(~(6'b000001 << i))});
        end
        fr_num++;
    endtask

    task automatic run_frame(input logic [23:0] dig, input logic bh, input logic bm);
        start_frame(dig, bh, bm);
        repeat (6 * SCAN_DIV) @(posedge clk);
        #1;
    endtask

    // Release reset and check the start-up blanking; ends at frame cycle 48.
    task automatic release_and_check();
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_c0_seg", 32'(seg_n), 32'h7F);
        check("rst_c0_dp",  32'(dp_n),  32'h1);
        check("rst_c0_an",  32'(an_n),  32'h3F);
        @(posedge clk); #1;
        check("rst_c1_seg", 32'(seg_n), 32'h7F);
        check("rst_c1_dp",  32'(dp_n),  32'h1);
        check("rst_c1_an",  32'(an_n),  32'h3F);
        @(posedge clk); #1;
        check("rst_c2_an",  32'(an_n),  32'h3F);
        @(posedge clk); #1;
        check("rst_c3_an",  32'(an_n),  32'h3E);
        repeat (6 * SCAN_DIV - 3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [13:0] cur = 14'h0;
    int          blank_run = 0;
    int          active_run = 0;
    bit          prev_active = 1'b0;
    bit          after_rst = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            blank_run   = 0;
            active_run  = 0;
            prev_active = 1'b0;
            after_rst   = 1'b1;
        end else if (an_n == 6'h3F) begin
            if (prev_active)
                check("active_len", 32'(active_run), 32'(SCAN_DIV - BLANK_CYC));
            prev_active = 1'b0;
            blank_run++;
        end else begin
            if (!prev_active) begin
                check("blank_len", 32'(blank_run), after_rst ? 32'(BLANK_CYC + 1) : 32'(BLANK_CYC));
                after_rst  = 1'b0;
                blank_run  = 0;
                active_run = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot_expected: got an_n %0h with no expected slot queued", an_n);
                    cur = {seg_n, dp_n, an_n};
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            check("slot_seg", 32'(seg_n), 32'(cur[13:7]));
            check("slot_dp",  32'(dp_n),  32'(cur[6]));
            check("slot_an",  32'(an_n),  32'(cur[5:0]));
            active_run++;
            prev_active = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (4) @(posedge clk);
        // frame 0: static 12:34:56
        start_frame(24'h123456, 1'b0, 1'b0);
        release_and_check();
        // frame 1: s_cntL changes to 7 during slot 3; still shows 6
        start_frame(24'h123456, 1'b0, 1'b0);
        repeat (28) @(posedge clk);
        #1 s_cntL = 4'd7;
        repeat (6 * SCAN_DIV - 28) @(posedge clk);
        #1;
        // frame 2: new snapshot shows 7; minutes blink (phase on)
        run_frame(24'h123457, 1'b0, 1'b1);
        run_frame(24'h123457, 1'b0, 1'b1);
        // frame 4: phase off, invalid BCD in minutes-units
        run_frame(24'h123C57, 1'b0, 1'b1);
        // frame 5: hours blink, phase off, leading zero hour
        run_frame(24'h095959, 1'b1, 1'b0);
        // frames 6-7: phase on, both fields / minutes only
        run_frame(24'h235948, 1'b1, 1'b1);
        run_frame(24'h050000, 1'b0, 1'b1);
        // frame 8: reset asserted mid-slot 2
        start_frame(24'h987654, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_seg", 32'(seg_n), 32'h7F);
        check("midrst_dp",  32'(dp_n),  32'h1);
        check("midrst_an",  32'(an_n),  32'h3F);
        exp_q.delete();
        fr_num = 0;
        repeat (2) @(posedge clk);
        // recovery frame after reset
        start_frame(24'h102030, 1'b0, 1'b0);
        release_and_check();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_time_scan.md
# seg7_time_scan

Time-of-day display driver for the clock datapath. Takes the six BCD digits produced by the clock/counter stage (HH:MM:SS) and scans them onto a six-digit, common-anode, multiplexed 7-segment display. Includes per-frame snapshotting to prevent tearing, anti-ghosting blanking, separator dots, and blinking of the field currently being adjusted. It sits directly downstream of the hour/minute/second counter stage and drives the board pins.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYC < SCAN_DIV.
- BLINK_FRAMES, 83: full frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock, the single clock domain.
- rst  in  1  reset, synchronous, active-high.
- h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL  in  4 each  BCD digits from the clock stage.
- blink_hr  in  1  high while hours are being adjusted.
- blink_min  in  1  high while minutes are being adjusted.
- seg_n  out  7  segments, active-low; bit 0 = a, through bit 6 = g.
- dp_n  out  1  decimal point, active-low.
- an_n  out  6  digit enables, active-low.
  - an_n[0] = s_cntL (rightmost), an_n[1] = s_cntH, an_n[2] = m_cntL, an_n[3] = m_cntH, an_n[4] = h_cntL, an_n[5] = h_cntH.

## Operation
- Slot prescaler p counts 0..SCAN_DIV-1 and wraps. At p = SCAN_DIV-1, digit index idx advances 0..5 and wraps to 0.
- One frame = 6·SCAN_DIV cycles.
- Snapshot: the six digits, blink_hr and blink_min are captured into internal registers on every cycle where p = 0 and idx = 0.
  - The display always shows a consistent frame.
  - Input changes mid-frame appear only in the next frame.
- Blink phase bit ph:
  - A frame counter counts completed frames 0..BLINK_FRAMES-1.
  - ph toggles on the frame boundary at which the counter wraps.
- Per-slot display value for digit d = snap[idx]:
  - Decode 0..9 to the standard pattern (active-low seg_n).
    - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19
    - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10
  - Codes 10..15 (invalid BCD) show a dash, 7'h3F.
  - dp_n = 0 only for idx 2 and 4 (separators after minutes and hours). In all other cases dp_n = 1.
  - Blink blanking: if snapshot blink_hr = 1 and ph = 1, idx 4 and 5 are blanked. If snapshot blink_min = 1 and ph = 1, idx 2 and 3 are blanked. Both may apply at once.
  - Blanked means seg_n = 7'h7F and dp_n = 1; the anode still drives normally.
- Anodes: an_n = 6'h3F while p < BLANK_CYC. Otherwise an_n = ~(1 << idx).

## Timing
- All outputs are registered. Each output reflects (p, idx, snapshot, ph) with 1 clk latency.
- Reset values (held while rst = 1, and on the first cycle after release):
  - seg_n = 7'h7F, dp_n = 1, an_n = 6'h3F.
  - p = 0, idx = 0, ph = 0, frame counter = 0, snapshot = 0.
- First cycle with rst = 0: p = 0 and idx = 0, so the snapshot loads. The blank interval guarantees no pre-snapshot data reaches the display.
- seg_n and dp_n change only on slot boundaries and at snapshot load, while an_n is all-off. No visible ghosting.
- Reset asserted mid-frame: on the next clk edge, all state and outputs return to reset values. No partial slot completes.
- Wrap: idx 5 → 0 coincides with the snapshot load and the frame-counter increment. ph toggles in that same cycle, when the counter wraps.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking is enabled.
  - When snapshot h_cntH = 0, slot idx 5 outputs seg_n = 7'h7F and dp_n = 1.
  - Its anode still follows the normal anode rule.
- SEG7_LZ_BLANK_EN undefined: h_cntH = 0 displays "0" (7'h40).

## Test plan
Bench parameters: SCAN_DIV = 8, BLANK_CYC = 2, BLINK_FRAMES = 2.
- Reset: hold rst for 5 clk, release → outputs stay at 7'h7F / 1 / 6'h3F for the first 3 cycles. an_n = 6'h3E appears at cycle 3 after release.
- Static 12:34:56 → over one 48-cycle frame, each slot shows the correct digit.
  - idx 0: seg_n = 7'h02 ("6"), an_n = 6'h3E.
  - idx 2: seg_n = 7'h19 ("4"), dp_n = 0.
  - idx 5: seg_n = 7'h79 ("1").
  - an_n = 6'h3F for the 2 leading cycles of every slot.
- Snapshot: change s_cntL 6 → 7 at idx 3 → slot 0 shows "6" until the next frame, then shows 7'h78.
- Blink: blink_min = 1 → slots 2 and 3 show 7'h7F in frames 2–3, 6–7, …, and show digits in frames 0–1, 4–5, ….
  - Same with blink_hr = 1 for slots 4 and 5.
  - Both asserted → four digits blank together.
- Invalid BCD: m_cntL = 4'hC → slot 2 shows 7'h3F with dp_n = 0.
- Macro: h_cntH = 0 → slot 5 shows 7'h7F with SEG7_LZ_BLANK_EN defined, and 7'h40 without it.
- Reset asserted mid-slot → all outputs return to reset values on the next edge.
